lane_deskew: RTL and testbench
==============================

LANE_DESKEW -- requirements
Module: lane_deskew

Interface
REQ-001 Parameter MAX_SKEW, 7, largest correctable inter-lane skew in enc_clk cycles (1..15).
REQ-002 Parameter ALIGN_SYM, 8'hF2, marker byte used for alignment on both lanes.
REQ-003 Parameter SW, ceil(log2(MAX_SKEW+1)), width of skew counter and skew_val.
REQ-004 Clocking and reset SHALL be: one clock enc_clk; reset rst is synchronous and active-low.
REQ-005 enc_clk  input  1  byte clock shared with the upstream decoder.
REQ-006 rst  input  1  synchronous active-low reset.
REQ-007 enable_deskew  input  1  upstream bytes are valid; low forces IDLE.
REQ-008 gen_speed  input  2  0=GEN4, 1=GEN3, 2=GEN2, 3=reserved.
REQ-009 lane_0_rx  input  8  decoded byte, lane 0.
REQ-010 lane_1_rx  input  8  decoded byte, lane 1.
REQ-011 lane_0_out  output  8  aligned byte, lane 0.
REQ-012 lane_1_out  output  8  aligned byte, lane 1.
REQ-013 data_valid  output  1  aligned bytes valid this cycle.
REQ-014 deskew_done  output  1  lock achieved and held.
REQ-015 skew_err  output  1  one-cycle pulse: skew exceeded MAX_SKEW or alignment lost.
REQ-016 skew_val  output  SW  measured skew, held while locked.
REQ-017 early_lane  output  1  0 = lane 0 marker arrived first (or simultaneous), 1 = lane 1 first.

Function
REQ-018 FSM states SHALL be IDLE, SEARCH, WAIT_LATE, LOCKED; IDLE->SEARCH on the first cycle enable_deskew=1.
REQ-019 SEARCH: ALIGN_SYM on both lanes in one cycle -> LOCKED, skew_val=0, early_lane=0.
REQ-020 SEARCH: ALIGN_SYM on one lane only -> WAIT_LATE, early_lane=that lane, counter=1.
REQ-021 WAIT_LATE: marker on late lane with counter=c -> LOCKED, skew_val=c; otherwise counter increments by 1 per cycle.
REQ-022 WAIT_LATE: early lane repeats marker before late lane -> counter restarts at 1, no error.
REQ-023 WAIT_LATE: counter reaches MAX_SKEW+1 without late marker -> skew_err pulse, SEARCH, counter=0.
REQ-024 LOCKED: early lane SHALL be delayed skew_val cycles and late lane 0 cycles, then both registered once; skew_val=0 gives 1-cycle latency.
REQ-025 data_valid SHALL rise the cycle after entry to LOCKED and stay high while LOCKED; deskew_done SHALL equal (state==LOCKED).
REQ-026 Outputs when data_valid=0 SHALL be 8'h00 on both lanes.
REQ-027 gen_speed=0 (GEN4): SEARCH SHALL skip to LOCKED immediately with skew_val=0 (bypass, single-source lanes).
REQ-028 gen_speed=3: block SHALL remain in IDLE.
REQ-029 enable_deskew falling in any state -> IDLE next cycle, data_valid/deskew_done low, skew_val and counter cleared, no skew_err.
REQ-030 gen_speed change while not IDLE SHALL be treated as enable_deskew falling.

Reset
REQ-031 On rst=0 at an enc_clk edge all outputs SHALL be 0, FSM IDLE, counter 0, delay lines zeroed.
REQ-032 Reset mid-LOCKED SHALL take effect the same edge; no skew_err emitted.

Configuration
REQ-033 Macro LANE_DESKEW_RELOCK_EN defined: in LOCKED, ALIGN_SYM on exactly one aligned output lane in a cycle -> skew_err pulse, deskew_done low, SEARCH next cycle.
REQ-034 Macro undefined: LOCKED exits only via enable_deskew low, gen_speed change or reset; marker mismatch ignored.

Structure
REQ-035 Shared package usb4_ll_pkg SHALL hold GEN4/GEN3/GEN2 codes, ALIGN_SYM default and the FSM state enum.
REQ-036 Sub-module deskew_delay_line (8-bit, depth MAX_SKEW, variable tap select) SHALL be instantiated once per lane.

Verification
REQ-037 Both lanes ALIGN_SYM same cycle, GEN3 -> skew_val=0, data_valid high next cycle, 1-cycle latency, bytes paired.
REQ-038 Lane 0 marker cycle 10, lane 1 cycle 13 -> skew_val=3, early_lane=0, lane_0 byte N emitted with lane_1 byte N+3-equivalent pairing aligned.
REQ-039 Lane 1 marker, no lane 0 marker for 8 cycles (MAX_SKEW=7) -> skew_err single pulse, SEARCH, then relock on next pair.
REQ-040 enable_deskew low for 1 cycle while LOCKED -> IDLE, outputs 0, relock from SEARCH after reassertion.
REQ-041 RELOCK_EN defined, LOCKED with skew 2, inject lane 1 shift by 1 -> skew_err pulse, deskew_done low; undefined -> lock held.
REQ-042 rst low during WAIT_LATE -> all outputs 0 at that edge; GEN4 afterwards -> LOCKED one cycle after enable.

Source files
------------

// File: rtl/usb4_ll_pkg.sv
// Shared USB4 link-layer definitions: link speed codes, default alignment
// marker and the lane deskew FSM state encoding.
package usb4_ll_pkg;

    localparam logic [1:0] GEN4     = 2'd0;
    localparam logic [1:0] GEN3     = 2'd1;
    localparam logic [1:0] GEN2     = 2'd2;
    localparam logic [1:0] GEN_RSVD = 2'd3;

    localparam logic [7:0] ALIGN_SYM_DEFAULT = 8'hF2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEARCH    = 2'd1,
        ST_WAIT_LATE = 2'd2,
        ST_LOCKED    = 2'd3
    } deskew_state_e;

    // True when a decoded byte is the alignment marker.
    function automatic logic is_marker(input logic [7:0] b, input logic [7:0] sym);
        return (b == sym);
    endfunction

endpackage

// File: rtl/deskew_delay_line.sv
// Byte-wide delay line with a selectable tap. tap = 0 passes the current
// input straight through; tap = k returns the byte seen k cycles ago.
// The shift register runs every cycle so history is available the moment
// a tap is selected.
module deskew_delay_line #(
    parameter int DEPTH = 7,
    parameter int TW    = $clog2(DEPTH + 1)
) (
    input  logic          enc_clk,
    input  logic          rst,
    input  logic [7:0]    din,
    input  logic [TW-1:0] tap,
    output logic [7:0]    dout
);

    logic [7:0] sr [DEPTH];

    // Shift history one stage per cycle; synchronous active-low clear.
    always_ff @(posedge enc_clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr[i] <= '0;
            end
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    // Tap select: zero is bypass, out-of-range taps also fall back to bypass.
    always_comb begin
        dout = din;
        for (int i = 1; i <= DEPTH; i++) begin
            if (int'(tap) == i) begin
                dout = sr[i-1];
            end
        end
    end

endmodule

// File: rtl/lane_deskew.sv
// Two-lane deskew: finds the alignment marker on both lanes, measures the
// inter-lane skew and then delays the early lane so that bytes leave paired.
// Optional feature macro: LANE_DESKEW_RELOCK_EN (marker mismatch on the
// aligned lanes while locked forces a re-search with a skew_err pulse).
//
// Stream semantics: data_valid qualifies lane_0_out/lane_1_out in the same
// cycle; there is no back-pressure, every valid cycle is a delivered pair,
// and both lane outputs read 8'h00 whenever data_valid is low.
module lane_deskew
    import usb4_ll_pkg::*;
#(
    parameter int         MAX_SKEW  = 7,
    parameter logic [7:0] ALIGN_SYM = ALIGN_SYM_DEFAULT,
    parameter int         SW        = $clog2(MAX_SKEW + 1)
) (
    input  logic          enc_clk,
    input  logic          rst,
    input  logic          enable_deskew,
    input  logic [1:0]    gen_speed,
    input  logic [7:0]    lane_0_rx,
    input  logic [7:0]    lane_1_rx,
    output logic [7:0]    lane_0_out,
    output logic [7:0]    lane_1_out,
    output logic          data_valid,
    output logic          deskew_done,
    output logic          skew_err,
    output logic [SW-1:0] skew_val,
    output logic          early_lane,
    output deskew_state_e state_dbg
);

    localparam logic [SW-1:0] CNT_MAX = SW'(MAX_SKEW);

    deskew_state_e state, state_n;
    logic [SW-1:0] cnt, cnt_n;
    logic [SW-1:0] skew_q, skew_n;
    logic          early_q, early_n;
    logic          err_q, err_n;
    logic [1:0]    gen_q;
    logic          dv_q;
    logic [7:0]    out0_q, out1_q;

    logic [SW-1:0] tap_0, tap_1;
    logic [7:0]    algn_0, algn_1;
    logic          mark_0, mark_1;
    logic          late_mark, early_mark;
    logic          speed_ok;
    logic          abort;
    logic          lock_hold;

    // Only the early lane is delayed; the late lane always taps zero.
    assign tap_0 = early_q ? '0 : skew_q;
    assign tap_1 = early_q ? skew_q : '0;

    deskew_delay_line #(.DEPTH(MAX_SKEW), .TW(SW)) u_dl_0 (
        .enc_clk (enc_clk),
        .rst     (rst),
        .din     (lane_0_rx),
        .tap     (tap_0),
        .dout    (algn_0)
    );

    deskew_delay_line #(.DEPTH(MAX_SKEW), .TW(SW)) u_dl_1 (
        .enc_clk (enc_clk),
        .rst     (rst),
        .din     (lane_1_rx),
        .tap     (tap_1),
        .dout    (algn_1)
    );

    assign mark_0     = is_marker(lane_0_rx, ALIGN_SYM);
    assign mark_1     = is_marker(lane_1_rx, ALIGN_SYM);
    assign late_mark  = early_q ? mark_0 : mark_1;
    assign early_mark = early_q ? mark_1 : mark_0;
    assign speed_ok   = (gen_speed == GEN4) || (gen_speed == GEN3) || (gen_speed == GEN2);

    // A speed change mid-operation is as disruptive as losing enable.
    assign abort      = (state != ST_IDLE) && (!enable_deskew || (gen_speed != gen_q));

`ifdef LANE_DESKEW_RELOCK_EN
    logic mark_a0, mark_a1;
    assign mark_a0 = is_marker(algn_0, ALIGN_SYM);
    assign mark_a1 = is_marker(algn_1, ALIGN_SYM);
`endif

    // Next-state, skew counter and lock bookkeeping.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        skew_n  = skew_q;
        early_n = early_q;
        err_n   = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_n   = '0;
                skew_n  = '0;
                early_n = 1'b0;
                if (enable_deskew && speed_ok) begin
                    state_n = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                cnt_n   = '0;
                skew_n  = '0;
                early_n = 1'b0;
                if ((gen_speed == GEN4) || (mark_0 && mark_1)) begin
                    // GEN4 lanes share one source: no measurement needed.
                    state_n = ST_LOCKED;
                end else if (mark_0) begin
                    state_n = ST_WAIT_LATE;
                    cnt_n   = SW'(1);
                end else if (mark_1) begin
                    state_n = ST_WAIT_LATE;
                    cnt_n   = SW'(1);
                    early_n = 1'b1;
                end
            end
            ST_WAIT_LATE: begin
                if (late_mark) begin
                    state_n = ST_LOCKED;
                    skew_n  = cnt;
                    cnt_n   = '0;
                end else if (early_mark) begin
                    // Early lane marked again: measure from the newer marker.
                    cnt_n = SW'(1);
                end else if (cnt == CNT_MAX) begin
                    // Next count would exceed the correctable window.
                    err_n   = 1'b1;
                    state_n = ST_SEARCH;
                    cnt_n   = '0;
                    early_n = 1'b0;
                end else begin
                    cnt_n = cnt + SW'(1);
                end
            end
            ST_LOCKED: begin
`ifdef LANE_DESKEW_RELOCK_EN
                if (mark_a0 != mark_a1) begin
                    err_n   = 1'b1;
                    state_n = ST_SEARCH;
                    skew_n  = '0;
                    early_n = 1'b0;
                end
`endif
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        if (abort) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            skew_n  = '0;
            early_n = 1'b0;
            err_n   = 1'b0;
        end
    end

    // FSM and measurement registers.
    always_ff @(posedge enc_clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            skew_q  <= '0;
            early_q <= 1'b0;
            err_q   <= 1'b0;
            gen_q   <= 2'd0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            skew_q  <= skew_n;
            early_q <= early_n;
            err_q   <= err_n;
            gen_q   <= gen_speed;
        end
    end

    // Bytes are emitted only while the lock survives into the next cycle.
    assign lock_hold = (state == ST_LOCKED) && (state_n == ST_LOCKED);

    // Output register stage for the aligned pair; zero when not valid.
    always_ff @(posedge enc_clk) begin
        if (!rst) begin
            dv_q   <= 1'b0;
            out0_q <= '0;
            out1_q <= '0;
        end else if (lock_hold) begin
            dv_q   <= 1'b1;
            out0_q <= algn_0;
            out1_q <= algn_1;
        end else begin
            dv_q   <= 1'b0;
            out0_q <= '0;
            out1_q <= '0;
        end
    end

    assign lane_0_out  = out0_q;
    assign lane_1_out  = out1_q;
    assign data_valid  = dv_q;
    assign deskew_done = (state == ST_LOCKED);
    assign skew_err    = err_q;
    assign skew_val    = skew_q;
    assign early_lane  = early_q;
    assign state_dbg   = state;

endmodule

// File: tb/tb_lane_deskew.sv
// Bench for lane_deskew: directed scenarios followed by a randomized run,
// all compared each cycle against a time-stamp based reference model.
module tb_lane_deskew;
    import usb4_ll_pkg::*;

    localparam int         MAX_SKEW = 7;
    localparam logic [7:0] SYM      = 8'hF2;
`ifdef LANE_DESKEW_RELOCK_EN
    localparam bit RELOCK = 1'b1;
`else
    localparam bit RELOCK = 1'b0;
`endif

    logic          enc_clk;
    logic          rst;
    logic          enable_deskew;
    logic [1:0]    gen_speed;
    logic [7:0]    lane_0_rx;
    logic [7:0]    lane_1_rx;
    logic [7:0]    lane_0_out;
    logic [7:0]    lane_1_out;
    logic          data_valid;
    logic          deskew_done;
    logic          skew_err;
    logic [2:0]    skew_val;
    logic          early_lane;
    deskew_state_e state_dbg;

    lane_deskew dut (
        .enc_clk       (enc_clk),
        .rst           (rst),
        .enable_deskew (enable_deskew),
        .gen_speed     (gen_speed),
        .lane_0_rx     (lane_0_rx),
        .lane_1_rx     (lane_1_rx),
        .lane_0_out    (lane_0_out),
        .lane_1_out    (lane_1_out),
        .data_valid    (data_valid),
        .deskew_done   (deskew_done),
        .skew_err      (skew_err),
        .skew_val      (skew_val),
        .early_lane    (early_lane),
        .state_dbg     (state_dbg)
    );

    // ---------------- clock ----------------
    initial enc_clk = 1'b0;
    always #5 enc_clk = ~enc_clk;

    // ---------------- scoreboard state ----------------
    int          n_vec  = 0;
    int          n_miss = 0;
    logic [15:0] exp_q[$];

    // Reference model: remembers every input byte by cycle number and
    // reasons in time stamps (marker time, elapsed cycles, lock skew).
    logic [7:0] h0 [0:4095];
    logic [7:0] h1 [0:4095];
    int   cyc      = 0;
    int   rst_mark = -1;
    bit   md_active, md_locked, md_pend, md_early;
    int   md_pt, md_skew;
    logic [1:0] md_gen;
    bit   e_dv, e_err;

    function automatic logic [7:0] hist(input int lane, input int idx);
        if (idx < 0 || idx <= rst_mark) return 8'h00;
        return (lane == 0) ? h0[idx] : h1[idx];
    endfunction

    function automatic logic [7:0] rnd();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        if (b == SYM) b = 8'h00;
        return b;
    endfunction

    task automatic model_clear();
        md_active = 0; md_locked = 0; md_pend = 0; md_early = 0; md_skew = 0;
    endtask

    task automatic model_step();
        bit m0, m1, late_m, early_m;
        int el;
        logic [7:0] a0, a1;
        h0[cyc] = lane_0_rx;
        h1[cyc] = lane_1_rx;
        m0 = (lane_0_rx == SYM);
        m1 = (lane_1_rx == SYM);
        e_dv = 0; e_err = 0;
        if (!rst) begin
            model_clear();
            rst_mark = cyc;
        end else if (md_active && (!enable_deskew || gen_speed != md_gen)) begin
            model_clear();
        end else if (!md_active) begin
            if (enable_deskew && gen_speed != 2'd3) md_active = 1;
        end else if (md_locked) begin
            a0 = md_early ? hist(0, cyc) : hist(0, cyc - md_skew);
            a1 = md_early ? hist(1, cyc - md_skew) : hist(1, cyc);
            if (RELOCK && ((a0 == SYM) != (a1 == SYM))) begin
                e_err = 1; md_locked = 0; md_skew = 0; md_early = 0;
            end else begin
                e_dv = 1;
                exp_q.push_back({a0, a1});
            end
        end else if (md_pend) begin
            el      = cyc - md_pt;
            late_m  = md_early ? m0 : m1;
            early_m = md_early ? m1 : m0;
            if (late_m) begin
                md_locked = 1; md_skew = el; md_pend = 0;
            end else if (early_m) begin
                md_pt = cyc;
            end else if (el == MAX_SKEW) begin
                e_err = 1; md_pend = 0; md_early = 0;
            end
        end else begin
            if (gen_speed == 2'd0 || (m0 && m1)) begin
                md_locked = 1; md_skew = 0; md_early = 0;
            end else if (m0) begin
                md_pend = 1; md_pt = cyc; md_early = 0;
            end else if (m1) begin
                md_pend = 1; md_pt = cyc; md_early = 1;
            end
        end
        md_gen = rst ? gen_speed : 2'd0;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- driver ----------------
    task automatic tick(input logic en, input logic [1:0] g, input logic [7:0] b0, input logic [7:0] b1);
        logic [15:0] pair;
        enable_deskew = en;
        gen_speed     = g;
        lane_0_rx     = b0;
        lane_1_rx     = b1;
        model_step();
        @(posedge enc_clk);
        #1;
        check("data_valid", data_valid, e_dv);
        check("deskew_done", deskew_done, md_locked);
        check("skew_err", skew_err, e_err);
        check("skew_val", skew_val, md_skew);
        check("early_lane", early_lane, md_early);
        if (e_dv) pair = exp_q.pop_front();
        else      pair = 16'h0000;
        check("lane_pair", {lane_0_out, lane_1_out}, pair);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic [1:0] g;
        logic       en;
        logic [7:0] b0, b1;
        rst = 1'b0;
        enable_deskew = 1'b0;
        gen_speed = 2'd1;
        lane_0_rx = 8'h00;
        lane_1_rx = 8'h00;

        // reset state
        repeat (3) tick(1'b1, 2'd1, rnd(), rnd());
        rst = 1'b1;
        tick(1'b0, 2'd1, rnd(), rnd());

        // GEN3, markers on both lanes in one cycle
        tick(1'b1, 2'd1, rnd(), rnd());
        tick(1'b1, 2'd1, SYM, SYM);
        repeat (10) tick(1'b1, 2'd1, rnd(), rnd());

        // enable dropped for one cycle while locked, then lane 0 leads by 3
        tick(1'b0, 2'd1, rnd(), rnd());
        tick(1'b1, 2'd1, rnd(), rnd());
        tick(1'b1, 2'd1, SYM, rnd());
        tick(1'b1, 2'd1, rnd(), rnd());
        tick(1'b1, 2'd1, rnd(), rnd());
        tick(1'b1, 2'd1, rnd(), SYM);
        repeat (10) tick(1'b1, 2'd1, rnd(), rnd());

        // lane 1 marker with no lane 0 marker inside the window
        tick(1'b0, 2'd1, rnd(), rnd());
        tick(1'b1, 2'd1, rnd(), rnd());
        tick(1'b1, 2'd1, rnd(), SYM);
        repeat (9) tick(1'b1, 2'd1, rnd(), rnd());
        // relock with lane 0 early by 2
        tick(1'b1, 2'd1, SYM, rnd());
        tick(1'b1, 2'd1, rnd(), rnd());
        tick(1'b1, 2'd1, rnd(), SYM);
        repeat (4) tick(1'b1, 2'd1, rnd(), rnd());
        // lane 1 marker shifted by one relative to the locked skew
        tick(1'b1, 2'd1, SYM, rnd());
        tick(1'b1, 2'd1, rnd(), rnd());
        tick(1'b1, 2'd1, rnd(), rnd());
        tick(1'b1, 2'd1, rnd(), SYM);
        repeat (6) tick(1'b1, 2'd1, rnd(), rnd());

        // lane 1 early by 5 under GEN2, then a speed change drops the lock
        tick(1'b0, 2'd2, rnd(), rnd());
        tick(1'b1, 2'd2, rnd(), rnd());
        tick(1'b1, 2'd2, rnd(), SYM);
        repeat (4) tick(1'b1, 2'd2, rnd(), rnd());
        tick(1'b1, 2'd2, SYM, rnd());
        repeat (8) tick(1'b1, 2'd2, rnd(), rnd());
        tick(1'b1, 2'd1, rnd(), rnd());
        repeat (2) tick(1'b1, 2'd1, rnd(), rnd());

        // reset during WAIT_LATE, then GEN4 bypass
        tick(1'b1, 2'd1, SYM, rnd());
        tick(1'b1, 2'd1, rnd(), rnd());
        rst = 1'b0;
        tick(1'b1, 2'd1, rnd(), rnd());
        rst = 1'b1;
        tick(1'b0, 2'd0, rnd(), rnd());
        tick(1'b1, 2'd0, rnd(), rnd());
        tick(1'b1, 2'd0, rnd(), rnd());
        repeat (5) tick(1'b1, 2'd0, rnd(), rnd());

        // reserved speed keeps the block idle
        tick(1'b0, 2'd3, rnd(), rnd());
        repeat (4) tick(1'b1, 2'd3, SYM, SYM);

        // randomized traffic
        g = 2'd1;
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
            en  = ($urandom_range(0, 79) != 0);
            if ($urandom_range(0, 119) == 0) g = 2'($urandom_range(0, 3));
            if (g == 2'd3 && $urandom_range(0, 9) == 0) g = 2'd2;
            b0 = ($urandom_range(0, 11) == 0) ? SYM : rnd();
            b1 = ($urandom_range(0, 11) == 0) ? SYM : rnd();
            tick(en, g, b0, b1);
        end
        rst = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
